// File: rtl/sm_irq_pkg.sv
// Shared definitions for the interrupt arbiter: register indices, CTRL bit
// positions and the handshake state encoding.
package sm_irq_pkg;

  localparam logic [2:0] IRQ_REG_PENDING = 3'd0;
  localparam logic [2:0] IRQ_REG_ENABLE  = 3'd1;
  localparam logic [2:0] IRQ_REG_EDGE    = 3'd2;
  localparam logic [2:0] IRQ_REG_CTRL    = 3'd3;
  localparam logic [2:0] IRQ_REG_CLAIM   = 3'd4;

  localparam int CTRL_RR  = 0;
  localparam int CTRL_GEN = 1;

  typedef enum logic [1:0] {
    IRQ_ST_IDLE    = 2'd0,
    IRQ_ST_ARB     = 2'd1,
    IRQ_ST_ACTIVE  = 2'd2,
    IRQ_ST_SERVICE = 2'd3
  } irq_state_e;

endpackage

// File: rtl/sm_irq_prio_enc.sv
// Combinational priority encoder: first set request at or above start_i,
// wrapping modulo N. start_i = 0 gives plain lowest-index priority.
module sm_irq_prio_enc #(
  parameter int N = 8
) (
  input  logic [N-1:0] req_i,
  input  logic [4:0]   start_i,
  output logic         found_o,
  output logic [4:0]   id_o
);

  always_comb begin
    int idx;
    idx     = 0;
    found_o = 1'b0;
    id_o    = '0;
    // Walk offsets from far to near so the nearest hit is the last assignment.
    for (int off = N - 1; off >= 0; off--) begin
      idx = (int'(start_i) + off) % N;
      if (((req_i >> idx) & N'(1)) != '0) begin
        found_o = 1'b1;
        id_o    = 5'(idx);
      end
    end
  end

endmodule

// File: rtl/sm_irq_arbiter.sv
// Arbitrates IRQ_NUM asynchronous sources onto cp0_ExcIP[0] with a
// claim/EOI handshake; forwards the CP0 timer onto cp0_ExcIP[5].
module sm_irq_arbiter
  import sm_irq_pkg::*;
#(
  parameter int IRQ_NUM     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IRQ_NUM-1:0] irq_in,
  input  logic               cp0_TI,
  input  logic [2:0]         bus_addr,
  input  logic               bus_we,
  input  logic               bus_re,
  input  logic [31:0]        bus_wd,
  output logic [31:0]        bus_rd,
  output logic [5:0]         cp0_ExcIP,
  output logic [4:0]         irq_id
);

  logic [IRQ_NUM-1:0] sync_q [SYNC_STAGES];
  logic [IRQ_NUM-1:0] dly_q;
  logic [IRQ_NUM-1:0] level, rise;
  logic [IRQ_NUM-1:0] pending_q, pending_d;
  logic [IRQ_NUM-1:0] enable_q, edge_mode_q;
  logic               rr_q, gen_q;
  logic [IRQ_NUM-1:0] cand, id_onehot;
  logic [4:0]         last_q, irq_id_q, rr_start, enc_start, win_id;
  logic               win_found, exc_q, claim, eoi, wr_pend;
  irq_state_e         state_q;
  logic               unused_wd;

  assign unused_wd = ^bus_wd[31:IRQ_NUM];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      dly_q <= '0;
    end else begin
      sync_q[0] <= irq_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      dly_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level     = sync_q[SYNC_STAGES-1];
  assign rise      = level & ~dly_q;
  assign id_onehot = IRQ_NUM'(1) << irq_id_q;
  assign wr_pend   = bus_we && (bus_addr == IRQ_REG_PENDING);
  assign claim     = bus_re && (bus_addr == IRQ_REG_CLAIM) && (state_q == IRQ_ST_ACTIVE);
  assign eoi       = bus_we && (bus_addr == IRQ_REG_CLAIM) && (state_q == IRQ_ST_SERVICE)
                     && (bus_wd[4:0] == irq_id_q);

  // A fresh edge beats a simultaneous W1C or claim so no request is lost.
  for (genvar gi = 0; gi < IRQ_NUM; gi++) begin : g_pend
    logic clr;
    assign clr = (wr_pend && bus_wd[gi]) || (claim && id_onehot[gi]);
    assign pending_d[gi] = edge_mode_q[gi] ? (rise[gi] | (pending_q[gi] & ~clr)) : level[gi];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q   <= '0;
      enable_q    <= '0;
      edge_mode_q <= '0;
      rr_q        <= 1'b0;
      gen_q       <= 1'b0;
    end else begin
      pending_q <= pending_d;
      if (bus_we && bus_addr == IRQ_REG_ENABLE) enable_q <= bus_wd[IRQ_NUM-1:0];
      if (bus_we && bus_addr == IRQ_REG_EDGE) edge_mode_q <= bus_wd[IRQ_NUM-1:0];
      if (bus_we && bus_addr == IRQ_REG_CTRL) begin
        rr_q  <= bus_wd[CTRL_RR];
        gen_q <= bus_wd[CTRL_GEN];
      end
    end
  end

  assign cand      = pending_q & enable_q & {IRQ_NUM{gen_q}};
  assign rr_start  = (last_q >= 5'(IRQ_NUM - 1)) ? 5'd0 : last_q + 5'd1;
  assign enc_start = rr_q ? rr_start : 5'd0;

  sm_irq_prio_enc #(.N(IRQ_NUM)) u_prio_enc (
    .req_i   (cand),
    .start_i (enc_start),
    .found_o (win_found),
    .id_o    (win_id)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IRQ_ST_IDLE;
      irq_id_q <= '0;
      last_q   <= '0;
      exc_q    <= 1'b0;
    end else begin
      case (state_q)
        IRQ_ST_IDLE: if (|cand) state_q <= IRQ_ST_ARB;
        IRQ_ST_ARB: begin
          if (win_found) begin
            irq_id_q <= win_id;
            exc_q    <= 1'b1;
            state_q  <= IRQ_ST_ACTIVE;
          end else begin
            state_q  <= IRQ_ST_IDLE;
          end
        end
        IRQ_ST_ACTIVE: begin
          if (claim) begin
            last_q  <= irq_id_q;
            exc_q   <= 1'b0;
            state_q <= IRQ_ST_SERVICE;
          end else if ((cand & id_onehot) == '0) begin
            exc_q   <= 1'b0;
            state_q <= IRQ_ST_IDLE;
          end
        end
        IRQ_ST_SERVICE: if (eoi) state_q <= IRQ_ST_IDLE;
        default: state_q <= IRQ_ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bus_rd = '0;
    case (bus_addr)
      IRQ_REG_PENDING: bus_rd[IRQ_NUM-1:0] = pending_q;
      IRQ_REG_ENABLE:  bus_rd[IRQ_NUM-1:0] = enable_q;
      IRQ_REG_EDGE:    bus_rd[IRQ_NUM-1:0] = edge_mode_q;
      IRQ_REG_CTRL: begin
        bus_rd[CTRL_RR]  = rr_q;
        bus_rd[CTRL_GEN] = gen_q;
      end
      IRQ_REG_CLAIM: if (state_q == IRQ_ST_ACTIVE) bus_rd = {1'b1, 26'b0, irq_id_q};
      default: bus_rd = '0;
    endcase
  end

  assign cp0_ExcIP = {cp0_TI, 4'b0000, exc_q};
  assign irq_id    = irq_id_q;

endmodule

// File: tb/tb_sm_irq_arbiter.sv
// Directed and randomized checks of sm_irq_arbiter against a transaction-level
// model of which source each claim should return.
module tb_sm_irq_arbiter;
  localparam int N = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  irq_in;
  logic          cp0_TI;
  logic [2:0]    bus_addr;
  logic          bus_we, bus_re;
  logic [31:0]   bus_wd, bus_rd;
  logic [5:0]    cp0_ExcIP;
  logic [4:0]    irq_id;

  int checks = 0;
  int failures = 0;
  int model_last = 0;

  always #5 clk = ~clk;

  sm_irq_arbiter #(.IRQ_NUM(N), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .irq_in    (irq_in),
    .cp0_TI    (cp0_TI),
    .bus_addr  (bus_addr),
    .bus_we    (bus_we),
    .bus_re    (bus_re),
    .bus_wd    (bus_wd),
    .bus_rd    (bus_rd),
    .cp0_ExcIP (cp0_ExcIP),
    .irq_id    (irq_id)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic peek(input logic [2:0] a, output logic [31:0] d);
    bus_addr = a;
    #1;
    d = bus_rd;
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [31:0] v);
    bus_addr = a;
    bus_wd   = v;
    bus_we   = 1'b1;
    tick();
    bus_we   = 1'b0;
    bus_wd   = '0;
  endtask

  task automatic claim_rd(output logic [31:0] d);
    bus_addr = 3'd4;
    bus_re   = 1'b1;
    #1;
    d = bus_rd;
    tick();
    bus_re   = 1'b0;
  endtask

  task automatic pulse(input logic [N-1:0] m);
    irq_in = m;
    tick();
    irq_in = '0;
  endtask

  task automatic wait_exc(input string tag);
    int n;
    n = 0;
    while (cp0_ExcIP[0] !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    chk(tag, {31'b0, cp0_ExcIP[0]}, 32'd1);
  endtask

  // Spec rule: fixed = lowest set index; RR = first set index after last, wrapping.
  function automatic int pick(input logic [N-1:0] p, input bit rr, input int last);
    int start;
    start = rr ? (last + 1) % N : 0;
    for (int o = 0; o < N; o++)
      if (p[(start + o) % N]) return (start + o) % N;
    return -1;
  endfunction

  task automatic claim_check(input string tag, input logic [N-1:0] cset, input bit rr,
                             output int w);
    logic [31:0] d;
    wait_exc({tag, "_exc"});
    claim_rd(d);
    w = pick(cset, rr, model_last);
    chk(tag, d, {1'b1, 26'b0, 5'(w)});
    model_last = w;
  endtask

  initial begin
    logic [31:0]  d;
    int           w, cnt;
    bit           rr;
    logic [N-1:0] m, en, pset;

    rst = 1'b1; irq_in = '0; cp0_TI = 1'b0; bus_addr = '0;
    bus_we = 1'b0; bus_re = 1'b0; bus_wd = '0;
    tick(); tick();
    rst = 1'b0;
    for (int a = 0; a < 8; a++) begin
      peek(3'(a), d);
      chk($sformatf("reset_reg%0d", a), d, 32'd0);
    end
    chk("reset_exc", {26'b0, cp0_ExcIP}, 32'd0);
    chk("reset_id", {27'b0, irq_id}, 32'd0);

    // Single edge source: latency, claim, EOI.
    bus_wr(3'd1, 32'hFF); bus_wr(3'd3, 32'h2); bus_wr(3'd2, 32'hFF);
    peek(3'd3, d); chk("ctrl_rb", d, 32'h2);
    peek(3'd1, d); chk("enable_rb", d, 32'hFF);
    irq_in = 8'h08; tick(); irq_in = '0;
    peek(3'd0, d); chk("t1_pend_p1", d, 32'h0);
    tick(); peek(3'd0, d); chk("t1_pend_p2", d, 32'h0);
    tick(); peek(3'd0, d); chk("t1_pend_p3", d, 32'h08);
    chk("t1_exc_p3", {26'b0, cp0_ExcIP}, 32'h0);
    tick(); chk("t1_exc_p4", {26'b0, cp0_ExcIP}, 32'h0);
    tick(); chk("t1_exc_p5", {26'b0, cp0_ExcIP}, 32'h01);
    claim_rd(d); chk("t1_claim", d, 32'h80000003); model_last = 3;
    peek(3'd0, d); chk("t1_pend_clr", d, 32'h0);
    chk("t1_exc_svc", {26'b0, cp0_ExcIP}, 32'h0);
    chk("t1_id", {27'b0, irq_id}, 32'd3);
    bus_wr(3'd4, 32'd3);
    chk("t1_exc_eoi", {26'b0, cp0_ExcIP}, 32'h0);
    claim_rd(d); chk("t1_claim_idle", d, 32'h0);

    // Fixed priority with two simultaneous edges.
    pulse(8'h24);
    claim_check("t2_first", 8'h24, 1'b0, w);
    bus_wr(3'd4, 32'(w));
    peek(3'd0, d); chk("t2_pend", d, 32'h20);
    claim_check("t2_second", 8'h20, 1'b0, w);
    bus_wr(3'd4, 32'(w));

    // Round-robin over two held level sources.
    bus_wr(3'd2, 32'h0); bus_wr(3'd3, 32'h3);
    irq_in = 8'h42;
    for (int i = 0; i < 4; i++) begin
      claim_check($sformatf("t3_rr%0d", i), 8'h42, 1'b1, w);
      if (i == 3) begin
        irq_in = '0;
        repeat (4) tick();
        peek(3'd0, d); chk("t3_pend_rel", d, 32'h0);
      end
      bus_wr(3'd4, 32'(w));
    end
    repeat (3) tick();
    chk("t3_idle", {26'b0, cp0_ExcIP}, 32'h0);

    // Disable while ACTIVE drops the request.
    bus_wr(3'd3, 32'h2);
    irq_in = 8'h10;
    wait_exc("t4_exc");
    chk("t4_id", {27'b0, irq_id}, 32'd4);
    bus_wr(3'd1, 32'h0);
    chk("t4_exc_hold", {31'b0, cp0_ExcIP[0]}, 32'd1);
    tick();
    chk("t4_exc_drop", {31'b0, cp0_ExcIP[0]}, 32'd0);
    claim_rd(d); chk("t4_claim", d, 32'h0);
    bus_wr(3'd4, 32'd4);
    repeat (3) tick();
    chk("t4_exc_eoi", {31'b0, cp0_ExcIP[0]}, 32'd0);
    claim_rd(d); chk("t4_claim2", d, 32'h0);
    irq_in = '0;
    repeat (4) tick();
    bus_wr(3'd1, 32'hFF);

    // Mismatched EOI, pending while in service, timer forwarding.
    bus_wr(3'd2, 32'hFF);
    cp0_TI = 1'b1;
    pulse(8'h04);
    claim_check("t5_claim", 8'h04, 1'b0, w);
    bus_wr(3'd4, 32'd7);
    chk("t5_exc_svc", {26'b0, cp0_ExcIP}, 32'h20);
    claim_rd(d); chk("t5_claim_svc", d, 32'h0);
    chk("t5_id", {27'b0, irq_id}, 32'd2);
    pulse(8'h01);
    repeat (5) tick();
    peek(3'd0, d); chk("t5_pend0", d, 32'h01);
    chk("t5_exc_wait", {26'b0, cp0_ExcIP}, 32'h20);
    bus_wr(3'd4, 32'd2);
    wait_exc("t5_exc0");
    chk("t5_exc_ti", {26'b0, cp0_ExcIP}, 32'h21);
    claim_check("t5_claim0", 8'h01, 1'b0, w);
    bus_wr(3'd4, 32'(w));
    cp0_TI = 1'b0;

    // Reset mid-SERVICE, then set-wins against a coincident W1C.
    pulse(8'h02);
    claim_check("t6_claim", 8'h02, 1'b0, w);
    rst = 1'b1;
    #1;
    chk("t6_rst_exc", {26'b0, cp0_ExcIP}, 32'h0);
    tick();
    rst = 1'b0;
    model_last = 0;
    for (int a = 0; a < 8; a++) begin
      peek(3'(a), d);
      chk($sformatf("t6_reg%0d", a), d, 32'd0);
    end
    chk("t6_id", {27'b0, irq_id}, 32'd0);
    bus_wr(3'd2, 32'hFF);
    irq_in = 8'h08; tick(); irq_in = '0;
    tick();
    bus_addr = 3'd0; bus_wd = 32'h08; bus_we = 1'b1;
    tick();
    bus_we = 1'b0; bus_wd = '0;
    peek(3'd0, d); chk("t6_set_wins", d, 32'h08);
    bus_wr(3'd0, 32'h08);
    peek(3'd0, d); chk("t6_w1c", d, 32'h0);

    // Randomized rounds: random sources, enables and mode.
    for (int r = 0; r < 10; r++) begin
      rr = 1'($urandom_range(0, 1));
      m  = N'($urandom);
      en = N'($urandom);
      bus_wr(3'd3, {30'b0, 1'b1, rr});
      bus_wr(3'd1, 32'(en));
      bus_wr(3'd2, 32'hFF);
      pulse(m);
      repeat (3) tick();
      pset = m;
      cnt  = $countones(m & en);
      for (int k = 0; k < cnt; k++) begin
        peek(3'd0, d); chk($sformatf("rnd%0d_pend%0d", r, k), d, 32'(pset));
        claim_check($sformatf("rnd%0d_claim%0d", r, k), pset & en, rr, w);
        pset[w] = 1'b0;
        bus_wr(3'd4, 32'(w));
      end
      repeat (4) tick();
      chk($sformatf("rnd%0d_idle", r), {31'b0, cp0_ExcIP[0]}, 32'd0);
      peek(3'd0, d); chk($sformatf("rnd%0d_left", r), d, 32'(pset));
      bus_wr(3'd0, 32'hFF);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
